// File: rtl/video_timing_m_pkg.sv
// Shared VGA 640x480@60 timing constants (one clock per two VGA pixels) and
// the 256x240 game window geometry used by the video pipeline.
package video_timing_m_pkg;

  localparam int H_VISIBLE = 320;
  localparam int H_FRONT   = 8;
  localparam int H_SYNC    = 48;
  localparam int H_BACK    = 24;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int X_OFFSET  = 32;
  localparam int GAME_W    = 256;
  localparam int GAME_H    = 240;

  localparam int HC_W      = 9;
  localparam int VC_W      = 10;

  // Half-open interval test done in signed int so zero lower bounds fold cleanly.
  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_m_axis.sv
// One timing axis: a wrapping counter plus sync/active window decode.
// Used once for the horizontal axis and once for the vertical axis.
module timing_axis_m
  import video_timing_m_pkg::*;
#(
  parameter int W       = 9,
  parameter int TOTAL   = 400,
  parameter int SYNC_LO = 328,
  parameter int SYNC_HI = 376,
  parameter int ACT_LO  = 0,
  parameter int ACT_HI  = 320
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_carry,
  output logic         o_sync_n,
  output logic         o_active
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(TOTAL - 1));

  // Counter advances when enabled and wraps to zero after TOTAL-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Combinational decode of the current count; the top registers these.
  always_comb begin
    o_cnt    = r_cnt;
    o_carry  = i_en & w_last;
    o_sync_n = ~in_range(int'(r_cnt), SYNC_LO, SYNC_HI);
    o_active = in_range(int'(r_cnt), ACT_LO, ACT_HI);
  end

endmodule

// File: rtl/video_timing_m.sv
// VGA sync and game-pixel timing generator with a sticky vblank interrupt.
// All outputs are registered decodes of the counter values one clock earlier.
module video_timing_m
  import video_timing_m_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK,
  parameter int X_OFS = X_OFFSET
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] xp,
  output logic [7:0] yp,
  output logic       visible,
  output logic       writable,
  output logic       vblank_irq,
  input  logic       irq_ack
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  logic [HC_W-1:0] w_h_cnt;
  logic [VC_W-1:0] w_v_cnt;
  logic            w_h_carry;
  logic            w_unused_v_carry;
  logic            w_h_sync_n;
  logic            w_v_sync_n;
  logic            w_h_act;
  logic            w_v_act;
  logic            w_vis;
  logic            w_irq_set;

  logic            r_hsync;
  logic            r_vsync;
  logic [7:0]      r_xp;
  logic [7:0]      r_yp;
  logic            r_visible;
  logic            r_writable;
  logic            r_irq;

  timing_axis_m #(
    .W       (HC_W),
    .TOTAL   (H_TOT),
    .SYNC_LO (H_VIS + H_FP),
    .SYNC_HI (H_VIS + H_FP + H_SW),
    .ACT_LO  (X_OFS),
    .ACT_HI  (X_OFS + GAME_W)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (1'b1),
    .o_cnt    (w_h_cnt),
    .o_carry  (w_h_carry),
    .o_sync_n (w_h_sync_n),
    .o_active (w_h_act)
  );

  // Vertical axis steps once per completed line.
  timing_axis_m #(
    .W       (VC_W),
    .TOTAL   (V_TOT),
    .SYNC_LO (V_VIS + V_FP),
    .SYNC_HI (V_VIS + V_FP + V_SW),
    .ACT_LO  (0),
    .ACT_HI  (V_VIS)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_h_carry),
    .o_cnt    (w_v_cnt),
    .o_carry  (w_unused_v_carry),
    .o_sync_n (w_v_sync_n),
    .o_active (w_v_act)
  );

  assign w_vis     = w_h_act & w_v_act;
  assign w_irq_set = (w_h_cnt == '0) && (w_v_cnt == VC_W'(V_VIS));

  // Register every output from the current counter decode; set beats ack on the irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_xp       <= '0;
      r_yp       <= '0;
      r_visible  <= 1'b0;
      r_writable <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_hsync    <= w_h_sync_n;
      r_vsync    <= w_v_sync_n;
      r_xp       <= w_vis ? 8'(w_h_cnt - HC_W'(X_OFS)) : 8'd0;
      r_yp       <= w_vis ? w_v_cnt[8:1] : 8'd0;
      r_visible  <= w_vis;
      r_writable <= ~w_v_act;
      r_irq      <= w_irq_set | (r_irq & ~irq_ack);
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign xp         = r_xp;
  assign yp         = r_yp;
  assign visible    = r_visible;
  assign writable   = r_writable;
  assign vblank_irq = r_irq;

endmodule

// File: tb/tb_video_timing_m.sv
// Bench for video_timing_m: full horizontal timing with a shortened vertical
// frame (24 visible lines, 33 total) so several frames fit in a short run.
module tb_video_timing_m;

  localparam int H_TOT = 400;
  localparam int VV    = 24;
  localparam int VF    = 3;
  localparam int VS    = 2;
  localparam int VB    = 4;
  localparam int V_TOT = VV + VF + VS + VB;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk;
  logic       rst;
  logic       irq_ack;
  logic       hsync;
  logic       vsync;
  logic [7:0] xp;
  logic [7:0] yp;
  logic       visible;
  logic       writable;
  logic       vblank_irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit irq_m = 1'b0;
  bit started = 1'b0;

  video_timing_m #(
    .V_VIS (VV),
    .V_FP  (VF),
    .V_SW  (VS),
    .V_BP  (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .xp         (xp),
    .yp         (yp),
    .visible    (visible),
    .writable   (writable),
    .vblank_irq (vblank_irq),
    .irq_ack    (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference: cycle index since release; counters are cyc mod frame.
  always @(posedge clk) begin
    if (rst) begin
      cyc   <= 0;
      irq_m <= 1'b0;
    end else begin
      if (cyc % FRAME == VV * H_TOT) irq_m <= 1'b1;
      else if (irq_ack)              irq_m <= 1'b0;
      cyc <= cyc + 1;
    end
  end

  // Every-cycle compare of all outputs against the reference.
  always @(negedge clk) begin
    int p, h, v;
    bit e_hs, e_vs, e_vis, e_wr;
    int e_xp, e_yp;
    if (started) begin
      if (cyc == 0) begin
        e_hs = 1; e_vs = 1; e_vis = 0; e_wr = 0; e_xp = 0; e_yp = 0;
      end else begin
        p     = (cyc - 1) % FRAME;
        h     = p % H_TOT;
        v     = p / H_TOT;
        e_hs  = !(h >= 328 && h < 376);
        e_vs  = !(v >= VV + VF && v < VV + VF + VS);
        e_vis = (h >= 32) && (h < 288) && (v < VV);
        e_xp  = e_vis ? h - 32 : 0;
        e_yp  = e_vis ? v / 2 : 0;
        e_wr  = (v >= VV);
      end
      chk("hsync", int'(hsync), int'(e_hs));
      chk("vsync", int'(vsync), int'(e_vs));
      chk("visible", int'(visible), int'(e_vis));
      chk("xp", int'(xp), e_xp);
      chk("yp", int'(yp), e_yp);
      chk("writable", int'(writable), int'(e_wr));
      chk("irq", int'(vblank_irq), int'(irq_m));
    end
  end

  initial begin
    int  phase;
    bit  done;
    rst     = 1'b1;
    irq_ack = 1'b0;
    phase   = 0;
    done    = 1'b0;
    @(posedge clk);
    started = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_visible", int'(visible), 0);
    chk("rst_irq", int'(vblank_irq), 0);
    rst = 1'b0;

    for (int n = 0; n < 60000 && !done; n++) begin
      @(negedge clk);
      irq_ack = 1'b0;
      if (rst) begin
        phase = 1;
        chk("mid_rst_hsync", int'(hsync), 1);
        chk("mid_rst_visible", int'(visible), 0);
        chk("mid_rst_xp", int'(xp), 0);
        chk("mid_rst_writable", int'(writable), 0);
        rst = 1'b0;
      end else if (phase == 0) begin
        case (cyc)
          32:    chk("vis_before", int'(visible), 0);
          33:    begin chk("vis_first", int'(visible), 1); chk("xp_first", int'(xp), 0); chk("yp_first", int'(yp), 0); end
          288:   begin chk("xp_last", int'(xp), 255); chk("vis_last", int'(visible), 1); end
          289:   chk("vis_after", int'(visible), 0);
          328:   chk("hs_pre", int'(hsync), 1);
          329:   chk("hs_fall", int'(hsync), 0);
          376:   chk("hs_lastlow", int'(hsync), 0);
          377:   chk("hs_rise", int'(hsync), 1);
          729:   chk("hs_period", int'(hsync), 0);
          833:   chk("yp_line2", int'(yp), 1);
          1233:  chk("yp_line3", int'(yp), 1);
          9233:  chk("yp_lastline", int'(yp), 11);
          9600:  begin chk("wr_pre", int'(writable), 0); chk("irq_pre", int'(vblank_irq), 0); end
          9601:  begin chk("wr_rise", int'(writable), 1); chk("irq_rise", int'(vblank_irq), 1); end
          9700:  chk("irq_hold", int'(vblank_irq), 1);
          9701:  chk("irq_acked", int'(vblank_irq), 0);
          10800: chk("vs_pre", int'(vsync), 1);
          10801: chk("vs_fall", int'(vsync), 0);
          11600: chk("vs_lastlow", int'(vsync), 0);
          11601: chk("vs_rise", int'(vsync), 1);
          13233: begin chk("frame2_vis", int'(visible), 1); chk("frame2_yp", int'(yp), 0); end
          22801: chk("irq_set_wins", int'(vblank_irq), 1);
          22802: chk("irq_set_wins2", int'(vblank_irq), 1);
          43800: begin chk("pre_rst_xp", int'(xp), 167); chk("pre_rst_yp", int'(yp), 5); end
          default: ;
        endcase
        if (cyc == 100 || cyc == 9700 || cyc == 22800) irq_ack = 1'b1;
        else if (cyc >= 26400 && $urandom_range(7) == 0) irq_ack = 1'b1;
        if (cyc == 43800) rst = 1'b1;
      end else begin
        if (cyc == 32) chk("resume_pre", int'(visible), 0);
        if (cyc == 33) begin
          chk("resume_vis", int'(visible), 1);
          chk("resume_yp", int'(yp), 0);
        end
        if ($urandom_range(7) == 0) irq_ack = 1'b1;
        if (cyc == 500) done = 1'b1;
      end
    end
    if (!done) chk("timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
